// File: rtl/ser_link_seq.sv
// Start-up sequencer and word scheduler for the tree serializer.
// Holds the clock divider in reset, sets its initial phase, sends a
// training burst, then feeds source words into fixed serializer load slots.
// Ports:
//   clk_i, rst_i (async, active-low)
//   en_i, init_phase_i           : link enable, divider initial phase
//   div_rst_o, div_init_o        : divider reset (active-low) and init value
//   s_data_i/s_valid_i/s_ready_o : upstream word source (s_ready_o combinational)
//   ser_data_o, ser_load_o       : registered word and load strobe to serializer
//   link_up_o, underrun_cnt_o    : link status, saturating underrun count
module ser_link_seq #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      SETTLE_CYCLES = 4,
  parameter int unsigned      TRAIN_WORDS   = 4,
  parameter int unsigned      WORD_CYCLES   = 4,
  parameter logic [WIDTH-1:0] TRAIN_WORD    = WIDTH'(8'hA5),
  parameter logic [WIDTH-1:0] IDLE_WORD     = WIDTH'(8'h00)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             init_phase_i,
  output logic             div_rst_o,
  output logic             div_init_o,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] ser_data_o,
  output logic             ser_load_o,
  output logic             link_up_o,
  output logic [7:0]       underrun_cnt_o
);

  // WAIT covers the divider's 3-stage reset stretch plus one cycle of margin
  localparam int unsigned WAIT_CYCLES = 4;
  localparam int unsigned CNT_MAX_A   = (SETTLE_CYCLES > WAIT_CYCLES) ? SETTLE_CYCLES : WAIT_CYCLES;
  localparam int unsigned CNT_MAX     = (TRAIN_WORDS > CNT_MAX_A) ? TRAIN_WORDS : CNT_MAX_A;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX);
  localparam int unsigned SC_W        = $clog2(WORD_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT,
    ST_TRAIN,
    ST_ACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             div_rst_q, div_rst_d;
  logic             div_init_q, div_init_d;
  logic [WIDTH-1:0] ser_data_q, ser_data_d;
  logic             ser_load_q, ser_load_d;
  logic             link_up_q, link_up_d;
  logic [7:0]       underrun_q, underrun_d;
  logic             slot_c;
  logic [SC_W-1:0]  sc_next_c;

  // Slot cycle is the last cycle of each serializer word slot
  always_comb begin
    slot_c    = (sc_q == SC_W'(WORD_CYCLES - 1));
    sc_next_c = slot_c ? '0 : sc_q + SC_W'(1);
    s_ready_o = (state_q == ST_ACTIVE) && slot_c && en_i;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sc_d       = '0;
    div_init_d = div_init_q;
    ser_data_d = ser_data_q;
    ser_load_d = 1'b0;
    underrun_d = underrun_q;

    if (!en_i) begin
      // Disable wins over every other transition; no load on the way out
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_RESET;
          cnt_d      = '0;
          div_init_d = init_phase_i;
          underrun_d = 8'd0;
        end
        ST_RESET: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_TRAIN: begin
          // cnt counts training words; sc carries on into ACTIVE
          sc_d = sc_next_c;
          if (slot_c) begin
            ser_data_d = TRAIN_WORD;
            ser_load_d = 1'b1;
            if (cnt_q == CNT_W'(TRAIN_WORDS - 1)) begin
              state_d = ST_ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ACTIVE: begin
          sc_d = sc_next_c;
          if (slot_c) begin
            ser_load_d = 1'b1;
            if (s_valid_i) begin
              ser_data_d = s_data_i;
            end else begin
              ser_data_d = IDLE_WORD;
              if (underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    div_rst_d = (state_d == ST_WAIT) || (state_d == ST_TRAIN) || (state_d == ST_ACTIVE);
    link_up_d = (state_d == ST_ACTIVE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sc_q       <= '0;
      div_rst_q  <= 1'b0;
      div_init_q <= 1'b0;
      ser_data_q <= '0;
      ser_load_q <= 1'b0;
      link_up_q  <= 1'b0;
      underrun_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sc_q       <= sc_d;
      div_rst_q  <= div_rst_d;
      div_init_q <= div_init_d;
      ser_data_q <= ser_data_d;
      ser_load_q <= ser_load_d;
      link_up_q  <= link_up_d;
      underrun_q <= underrun_d;
    end
  end

  assign div_rst_o      = div_rst_q;
  assign div_init_o     = div_init_q;
  assign ser_data_o     = ser_data_q;
  assign ser_load_o     = ser_load_q;
  assign link_up_o      = link_up_q;
  assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_ser_link_seq.sv
// Scoreboard bench for ser_link_seq: stimulus pushes expected loads,
// a negedge monitor compares loads and the link status outputs.
module tb_ser_link_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       init_phase_i = 1'b0;
  logic [7:0] s_data_i = 8'h00;
  logic       s_valid_i = 1'b0;
  logic       div_rst_o, div_init_o, s_ready_o, ser_load_o, link_up_o;
  logic [7:0] ser_data_o, underrun_cnt_o;

  ser_link_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .init_phase_i(init_phase_i),
    .div_rst_o(div_rst_o), .div_init_o(div_init_o),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .ser_data_o(ser_data_o), .ser_load_o(ser_load_o), .link_up_o(link_up_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   start_e0 = -1;
  int   stop_e = -1;
  logic exp_init = 1'b0;
  bit   mon_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, cyc);
  endtask

  // Reference model of the status outputs relative to the start edge E0
  task automatic monitor_check();
    bit run;
    int rel;
    run = (start_e0 >= 0) && (cyc >= start_e0) && (stop_e < 0 || cyc < stop_e);
    rel = cyc - start_e0;
    chk("div_rst", 32'(div_rst_o), 32'(run && rel >= 4));
    chk("link_up", 32'(link_up_o), 32'(run && rel >= 24));
    chk("s_ready", 32'(s_ready_o), 32'(run && en_i && rel >= 27 && ((rel - 27) % 4) == 0));
    if (run) chk("div_init", 32'(div_init_o), 32'(exp_init));
    if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
      chk("load_strobe", 32'(ser_load_o), 1);
      chk("load_data", 32'(ser_data_o), 32'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("no_load", 32'(ser_load_o), 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      if (mon_en) monitor_check();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got edge %0d expected completion", cyc);
    $fatal(1);
  end

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_load(input int e, input logic [7:0] d);
    exp_t x;
    x.edge_n = e;
    x.data   = d;
    exp_q.push_back(x);
  endtask

  // Called at posedge+1; the next edge is E0
  task automatic start_link(input logic ph, output int e0);
    init_phase_i = ph;
    exp_init     = ph;
    en_i         = 1'b1;
    stop_e       = -1;
    e0           = cyc + 1;
    start_e0     = e0;
    for (int k = 1; k <= 4; k++) push_load(e0 + 8 + 4 * k, 8'hA5);
  endtask

  task automatic stop_link();
    en_i   = 1'b0;
    stop_e = cyc + 1;
  endtask

  task automatic chk_all_reset();
    chk("rst_div_rst", 32'(div_rst_o), 0);
    chk("rst_div_init", 32'(div_init_o), 0);
    chk("rst_ser_data", 32'(ser_data_o), 0);
    chk("rst_ser_load", 32'(ser_load_o), 0);
    chk("rst_s_ready", 32'(s_ready_o), 0);
    chk("rst_link_up", 32'(link_up_o), 0);
    chk("rst_underrun", 32'(underrun_cnt_o), 0);
  endtask

  initial begin
    int e0;
    #3 rst_i = 1'b0;
    #1 chk_all_reset();
    step_to(3);
    rst_i  = 1'b1;
    mon_en = 1'b1;
    step_to(5);

    // Start-up with phase 1, then three user words
    start_link(1'b1, e0);
    s_valid_i = 1'b1;
    s_data_i  = 8'h01;
    push_load(e0 + 28, 8'h01);
    push_load(e0 + 32, 8'h02);
    push_load(e0 + 36, 8'h03);
    step_to(e0 + 28);
    s_data_i = 8'h02;
    step_to(e0 + 32);
    s_data_i = 8'h03;
    step_to(e0 + 36);
    chk("underrun_none", 32'(underrun_cnt_o), 0);
    s_valid_i = 1'b0;
    s_data_i  = 8'h55;

    // 300 empty slots: idle words and saturating underrun count
    for (int k = 0; k < 300; k++) push_load(e0 + 40 + 4 * k, 8'h00);
    step_to(e0 + 40 + 4 * 99);
    chk("underrun_100", 32'(underrun_cnt_o), 100);
    step_to(e0 + 40 + 4 * 299);
    chk("underrun_sat", 32'(underrun_cnt_o), 255);

    // Drop enable on a slot cycle with valid data offered
    step_to(e0 + 1239);
    s_valid_i = 1'b1;
    s_data_i  = 8'h77;
    stop_link();
    #1 chk("ready_on_drop", 32'(s_ready_o), 0);
    step_to(e0 + 1243);
    s_valid_i = 1'b0;

    // Re-enable with phase 0: full sequence again, underrun cleared
    start_link(1'b0, e0);
    step_to(e0);
    chk("underrun_clear", 32'(underrun_cnt_o), 0);
    push_load(e0 + 28, 8'h00);
    push_load(e0 + 32, 8'h00);
    step_to(e0 + 33);
    chk("underrun_two", 32'(underrun_cnt_o), 2);
    stop_link();
    step_to(e0 + 38);

    // Async reset between edges in the middle of training
    start_link(1'b1, e0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    step_to(e0 + 14);
    #1;
    rst_i    = 1'b0;
    start_e0 = -1;
    #1 chk_all_reset();
    step_to(e0 + 17);
    rst_i = 1'b1;
    e0       = cyc + 1;
    start_e0 = e0;
    for (int k = 1; k <= 4; k++) push_load(e0 + 8 + 4 * k, 8'hA5);
    step_to(e0 + 26);
    stop_link();
    step_to(e0 + 30);

    // Drop enable during WAIT: no load may follow
    start_link(1'b0, e0);
    repeat (4) void'(exp_q.pop_back());
    step_to(e0 + 5);
    stop_link();
    step_to(e0 + 40);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ser_link_seq.md
# ser_link_seq

Start-up sequencer and word scheduler for the low-power tree serializer. It holds the quadrature clock divider in reset and sets its initial phase. After the divider has settled it sends a fixed training burst, then feeds parallel words from a valid/ready source into the serializer, one word per fixed slot. It sits between the upstream data source and the clk_divider/serializer pair, sharing the serializer load slots between training and user traffic.

## Interface
- WIDTH, 8: parallel word width.
- SETTLE_CYCLES, 4: cycles the divider reset is held low (≥1).
- TRAIN_WORDS, 4: number of training words sent before link-up (≥1).
- WORD_CYCLES, 4: clk_i cycles per serializer word slot (≥2).
- TRAIN_WORD, 8'hA5: training word value (WIDTH bits).
- IDLE_WORD, 8'h00: fill word loaded in an active slot with no valid data.
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-low reset.
- en_i  in  1  link enable; level-sensitive.
- init_phase_i  in  1  divider initial phase, sampled on start.
- div_rst_o  out  1  active-low reset to clk_divider; driven from a dedicated flop.
- div_init_o  out  1  init value to clk_divider.
- s_data_i  in  WIDTH  source word.
- s_valid_i  in  1  source word valid.
- s_ready_o  out  1  source ready; combinational.
- ser_data_o  out  WIDTH  word to serializer; registered.
- ser_load_o  out  1  one-cycle load strobe for ser_data_o; registered.
- link_up_o  out  1  high in ACTIVE.
- underrun_cnt_o  out  8  saturating count of active slots with no valid data.

## Operation
- States: IDLE, RESET, WAIT, TRAIN, ACTIVE.
  - IDLE → RESET when en_i = 1. On this transition, capture init_phase_i into div_init_o and clear underrun_cnt_o.
  - RESET lasts SETTLE_CYCLES cycles, then → WAIT.
  - WAIT lasts 4 cycles, which covers the divider's 3-stage reset stretch, then → TRAIN.
  - TRAIN lasts TRAIN_WORDS × WORD_CYCLES cycles, then → ACTIVE.
  - ACTIVE holds until en_i = 0.
- Any state with en_i = 0 → IDLE at the next edge. This has priority over all other transitions.
- Reset level:
  - div_rst_o = 0 in IDLE and RESET.
  - div_rst_o = 1 in WAIT, TRAIN and ACTIVE.
  - It changes on the same edge as the state.
- Slot counter sc (0..WORD_CYCLES-1):
  - Zero on entry to TRAIN.
  - Increments every cycle in TRAIN and ACTIVE, wrapping to 0.
  - Continues across the TRAIN → ACTIVE boundary without restart.
- Slot cycle: the cycle with sc = WORD_CYCLES-1. At the edge ending a slot cycle, ser_data_o is loaded and ser_load_o is set for exactly one cycle.
  - In TRAIN, the loaded word is TRAIN_WORD.
  - In ACTIVE with s_valid_i = 1, the loaded word is s_data_i, and the transfer completes.
  - In ACTIVE with s_valid_i = 0, the loaded word is IDLE_WORD, and underrun_cnt_o increments, saturating at 255.
- s_ready_o = (state = ACTIVE) & (sc = WORD_CYCLES-1) & en_i. A word is never accepted in the cycle en_i falls.
- Leaving to IDLE:
  - No load occurs.
  - ser_data_o holds its last value.
  - ser_load_o and link_up_o go 0.
  - div_init_o holds until the next start.
- Async reset, also mid-operation, drives all outputs to their reset values immediately, without a clock:
  - state IDLE, div_rst_o 0, div_init_o 0, ser_data_o 0, ser_load_o 0, s_ready_o 0, link_up_o 0, underrun_cnt_o 0.

## Timing
- All timing below uses the defaults. E0 is the edge that samples en_i = 1 in IDLE.
- RESET occupies E0–E4. div_rst_o rises at E4, WAIT begins at E4, and TRAIN begins at E8.
- Training loads occur at E12, E16, E20 and E24. ser_load_o is high for the one cycle after each of these edges.
- ACTIVE and link_up_o = 1 begin at E24.
- The first s_ready_o cycle is E27–E28, and the first user word is loaded at E28.
- Steady state: one load every WORD_CYCLES cycles. Load latency is 1 edge from an accepted handshake to ser_data_o/ser_load_o.
- en_i low sampled at edge En: IDLE and div_rst_o = 0 from En.

## Test plan
- Start-up, init_phase_i = 1, en_i held → div_rst_o 0 until E4; div_init_o = 1 from E0; exactly 4 loads of 8'hA5 at E12/16/20/24; link_up_o rises at E24.
- ACTIVE, s_valid_i always 1 with incrementing data 8'h01, 8'h02, … → loads at E28, E32, E36 carry 8'h01, 8'h02, 8'h03; no other load strobes; underrun_cnt_o stays 0.
- ACTIVE, s_valid_i = 0 for 300 slots → 300 loads of 8'h00; underrun_cnt_o saturates at 255; s_ready_o high only on slot cycles.
- en_i dropped on an ACTIVE slot cycle with s_valid_i = 1 → s_ready_o 0 in that cycle; no load; IDLE, div_rst_o 0 and link_up_o 0 at the next edge; re-enable repeats the full E0–E24 sequence with underrun_cnt_o cleared.
- rst_i asserted asynchronously mid-TRAIN, between edges → all outputs at reset values immediately; after release with en_i high, start-up restarts from IDLE.
- en_i dropped during WAIT → IDLE at the next edge; no ser_load_o pulse ever issued.
